// File: rtl/ai_conn_pkg.sv
// Shared window-stream definitions for the 3x3 collector / serializer pair.
package ai_conn_pkg;

    localparam int unsigned WIN_DW     = 8;
    localparam int unsigned WIN_N_ELEM = 9;
    localparam int unsigned WIN_IDX_W  = 4;

    // One complete window; element k occupies bits [k*WIN_DW +: WIN_DW].
    typedef logic [WIN_N_ELEM*WIN_DW-1:0] win3x3_t;

endpackage

// File: rtl/win_idx_cnt.sv
// Modulo-N element index counter; advances on en and wraps only after the last index.
module win_idx_cnt #(
    parameter int unsigned N = 9,
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         is_last
);

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    assign is_last = (cnt == LAST_IDX);

    // Step the index on each accepted beat, returning to 0 after the last element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= is_last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/win3x3_serializer.sv
// Serializes a parallel window into an element stream; active + pending buffers
// let a second window wait so consecutive windows stream without bubbles.
module win3x3_serializer
    import ai_conn_pkg::*;
#(
    parameter int unsigned DW     = WIN_DW,
    parameter int unsigned N_ELEM = WIN_N_ELEM,
    parameter int unsigned IDX_W  = WIN_IDX_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [N_ELEM*DW-1:0]   in_win,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [DW-1:0]          out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   busy
);

    logic                 act_vld;
    logic                 pnd_vld;
    logic [N_ELEM*DW-1:0] act_win;
    logic [N_ELEM*DW-1:0] pnd_win;
    logic [IDX_W-1:0]     cnt;
    logic                 cnt_last;
    logic                 acc;
    logic                 fire;
    logic                 fire_last;

    // in_rdy depends only on held state, never on out_rdy.
    assign in_rdy    = ~pnd_vld;
    assign acc       = in_vld && in_rdy;
    assign fire      = act_vld && out_rdy;
    assign fire_last = fire && cnt_last;

    assign out_vld   = act_vld;
    assign out_idx   = cnt;
    assign out_data  = act_win[int'(cnt)*DW +: DW];
    assign out_first = act_vld && (cnt == '0);
    assign out_last  = act_vld && cnt_last;
    assign busy      = act_vld || pnd_vld;

    win_idx_cnt #(
        .N (N_ELEM),
        .W (IDX_W)
    ) u_idx_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (fire),
        .cnt     (cnt),
        .is_last (cnt_last)
    );

    // Load the active/pending buffers: on the last beat promote pending (or bypass
    // the incoming window), otherwise fill whichever buffer is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_vld <= 1'b0;
            pnd_vld <= 1'b0;
            act_win <= '0;
            pnd_win <= '0;
        end else if (fire_last) begin
            if (pnd_vld) begin
                act_win <= pnd_win;
                pnd_vld <= 1'b0;
            end else if (acc) begin
                act_win <= in_win;
            end else begin
                act_vld <= 1'b0;
            end
        end else if (acc) begin
            if (!act_vld) begin
                act_win <= in_win;
                act_vld <= 1'b1;
            end else begin
                pnd_win <= in_win;
                pnd_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_win3x3_serializer.sv
// Self-checking bench for win3x3_serializer: directed scenarios plus a randomized
// run scored against a queue-based window/element model.
module tb_win3x3_serializer;
    import ai_conn_pkg::*;

    localparam int unsigned DW = WIN_DW;
    localparam int unsigned NE = WIN_N_ELEM;
    localparam int unsigned IW = WIN_IDX_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic          in_rdy;
    win3x3_t       in_win;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_first;
    logic          out_last;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    win3x3_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_win    (in_win),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Advance one clock; sampling happens 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic win3x3_t make_win(input int base);
        win3x3_t w;
        for (int k = 0; k < int'(NE); k++) w[k*DW +: DW] = DW'(base + k);
        return w;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; in_win = '0;
        step(); step();
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
        checks++; if (out_idx !== '0) begin failures++; $display("FAIL reset_out_idx got=%0d exp=0", out_idx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_first !== 1'b0 || out_last !== 1'b0) begin
            failures++; $display("FAIL reset_first_last got=%b%b exp=00", out_first, out_last); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_vld !== 1'b0 || in_rdy !== 1'b1 || busy !== 1'b0) begin
                failures++; $display("FAIL post_reset_idle cyc=%0d got vld=%b rdy=%b busy=%b exp 0 1 0",
                                     i, out_vld, in_rdy, busy);
            end
        end
    endtask

    task automatic test_single();
        in_win = make_win(1); in_vld = 1'b1; out_rdy = 1'b1;
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL single_in_rdy got=%b exp=1", in_rdy); end
        step();
        in_vld = 1'b0;
        for (int k = 0; k < int'(NE); k++) begin
            checks++;
            if (out_vld !== 1'b1 || out_data !== DW'(k + 1) || out_idx !== IW'(k)
                || out_first !== (k == 0) || out_last !== (k == int'(NE) - 1)) begin
                failures++;
                $display("FAIL single_beat k=%0d got vld=%b data=%0d idx=%0d f=%b l=%b", k,
                         out_vld, out_data, out_idx, out_first, out_last);
            end
            step();
        end
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL single_end_vld got=%b exp=0", out_vld); end
    endtask

    task automatic test_back_to_back();
        int exp_d;
        in_win = make_win(8'h10); in_vld = 1'b1; out_rdy = 1'b1;
        step();
        in_win = make_win(8'h20);
        for (int i = 0; i < 2 * int'(NE); i++) begin
            exp_d = (i < int'(NE)) ? 8'h10 + i : 8'h20 + i - int'(NE);
            checks++;
            if (out_vld !== 1'b1 || out_data !== DW'(exp_d) || out_idx !== IW'(i % int'(NE))) begin
                failures++;
                $display("FAIL b2b_beat i=%0d got vld=%b data=%h idx=%0d exp data=%h", i,
                         out_vld, out_data, out_idx, exp_d);
            end
            checks++;
            if (in_rdy !== !(i >= 1 && i < int'(NE))) begin
                failures++; $display("FAIL b2b_in_rdy i=%0d got=%b", i, in_rdy);
            end
            step();
            in_vld = 1'b0;
        end
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL b2b_end_vld got=%b exp=0", out_vld); end
    endtask

    task automatic test_backpressure();
        int e;
        int stall;
        e = 0; stall = 0;
        in_win = make_win(1); in_vld = 1'b1; out_rdy = 1'b1;
        step();
        in_vld = 1'b0;
        for (int c = 0; c < 200 && e < int'(NE); c++) begin
            out_rdy = !(e == 4 && stall < 5);
            if (!out_rdy) stall++;
            checks++;
            if (out_vld !== 1'b1 || out_data !== DW'(e + 1) || out_idx !== IW'(e)) begin
                failures++;
                $display("FAIL bp_beat e=%0d got vld=%b data=%0d idx=%0d", e, out_vld, out_data, out_idx);
            end
            if (out_rdy) e++;
            step();
        end
        out_rdy = 1'b1;
        checks++; if (out_vld !== 1'b0 || stall != 5) begin
            failures++; $display("FAIL bp_end got vld=%b stalls=%0d exp 0 5", out_vld, stall); end
    endtask

    task automatic test_reset_mid();
        in_win = make_win(8'h30); in_vld = 1'b1; out_rdy = 1'b1;
        step();
        in_win = make_win(8'h40);
        for (int i = 0; i < 6; i++) begin step(); in_vld = 1'b0; end
        checks++;
        if (out_idx !== IW'(6) || busy !== 1'b1 || in_rdy !== 1'b0) begin
            failures++; $display("FAIL mid_pre idx=%0d busy=%b rdy=%b exp 6 1 0", out_idx, busy, in_rdy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1 || busy !== 1'b0 || out_idx !== '0) begin
            failures++; $display("FAIL mid_reset got vld=%b rdy=%b busy=%b idx=%0d", out_vld, in_rdy, busy, out_idx);
        end
        step();
        rst_n = 1'b1;
        step();
        in_win = make_win(8'h50); in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        for (int k = 0; k < int'(NE); k++) begin
            checks++;
            if (out_vld !== 1'b1 || out_data !== DW'(8'h50 + k) || out_idx !== IW'(k)) begin
                failures++; $display("FAIL mid_after k=%0d got data=%h idx=%0d", k, out_data, out_idx);
            end
            step();
        end
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL mid_end_vld got=%b exp=0", out_vld); end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        int idx_q[$];
        int held, sent, done, lasts, beats;
        bit acc, fire;
        held = 0; sent = 0; done = 0; lasts = 0; beats = 0;
        in_vld = 1'b0; out_rdy = 1'b0;
        for (int c = 0; c < 5000 && done < 50; c++) begin
            checks++;
            if (out_vld !== (held > 0) || in_rdy !== (held <= 1) || busy !== (held > 0)) begin
                failures++;
                $display("FAIL rnd_flags c=%0d got vld=%b rdy=%b busy=%b held=%0d", c, out_vld, in_rdy, busy, held);
            end
            in_vld  = (sent < 50) && ($urandom_range(1, 0) == 1);
            out_rdy = ($urandom_range(1, 0) == 1);
            for (int k = 0; k < int'(NE); k++) in_win[k*DW +: DW] = DW'($urandom);
            acc  = in_vld && (held <= 1);
            fire = (held > 0) && out_rdy;
            if (held > 0) begin
                checks++;
                if (out_data !== exp_q[0] || out_idx !== IW'(idx_q[0]) || out_first !== (idx_q[0] == 0)
                    || out_last !== (idx_q[0] == int'(NE) - 1)) begin
                    failures++;
                    $display("FAIL rnd_beat c=%0d got data=%h idx=%0d f=%b l=%b exp data=%h idx=%0d",
                             c, out_data, out_idx, out_first, out_last, exp_q[0], idx_q[0]);
                end
            end
            if (fire) begin
                beats++;
                if (out_last) lasts++;
                if (idx_q[0] == int'(NE) - 1) begin held--; done++; end
                void'(exp_q.pop_front());
                void'(idx_q.pop_front());
            end
            if (acc) begin
                for (int k = 0; k < int'(NE); k++) begin
                    exp_q.push_back(in_win[k*DW +: DW]);
                    idx_q.push_back(k);
                end
                held++; sent++;
            end
            step();
        end
        in_vld = 1'b0; out_rdy = 1'b1;
        checks++;
        if (done != 50 || beats != 50 * int'(NE) || lasts != 50) begin
            failures++; $display("FAIL rnd_totals windows=%0d beats=%0d lasts=%0d exp 50 %0d 50",
                                 done, beats, lasts, 50 * int'(NE));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
